alu_arbiter: RTL and testbench

Shares the single combinational ALU between two requesters, for example the execute path and an address/branch-compare helper. Each requester issues an operation (A, B, ALU select) over a valid/ready request channel and receives the result, carry and zero over a valid/ready response channel. The block arbitrates round-robin, registers operands, drives the ALU for one cycle, captures its outputs and holds the response until it is accepted. Only one operation is in flight at a time.

---
 rtl/alu_arbiter.sv | 176 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant, registered operands, one EXEC cycle, and a held
// response that stays valid until the owning requester accepts it.
// Only one operation is in flight at any time.
//
// Handshake rule for both channels: a transfer happens on a rising clk
// edge where valid and ready are both 1. req_ready is only ever raised in
// IDLE, for the granted requester, while its req_valid is high. rsp_valid
// is only raised in RESP, for the owner, and stays high with stable
// rsp_data/rsp_carry/rsp_zero until rsp_ready[owner] is seen at an edge.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [SEL_W-1:0] req_sel0,
    input  logic [SEL_W-1:0] req_sel1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic             busy,
    output logic             owner,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_last_grant;
    logic               r_owner;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [SEL_W-1:0]   r_op_sel;
    logic [WIDTH-1:0]   r_rsp_data;
    logic               r_rsp_carry;
    logic               r_rsp_zero;

    logic               w_grant;
    logic               w_accept;
    logic [WIDTH-1:0]   w_grant_a;
    logic [WIDTH-1:0]   w_grant_b;
    logic [SEL_W-1:0]   w_grant_sel;

    // Arbitration: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        w_grant = r_last_grant;
        case (req_valid)
            2'b01:   w_grant = 1'b0;
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = ~r_last_grant;
            default: w_grant = r_last_grant;
        endcase
    end

    // Operand mux selecting the granted requester's A/B/select.
    always_comb begin
        w_grant_a   = req_a0;
        w_grant_b   = req_b0;
        w_grant_sel = req_sel0;
        if (w_grant) begin
            w_grant_a   = req_a1;
            w_grant_b   = req_b1;
            w_grant_sel = req_sel1;
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid[w_grant]) begin
                    req_ready[w_grant] = 1'b1;
                    w_accept           = 1'b1;
                    w_state_nxt        = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid[r_owner] = 1'b1;
                if (rsp_ready[r_owner]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant bookkeeping: owner and round-robin pointer update on accept.
    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
            r_owner      <= w_grant;
        end
    end

    // Operand registers: loaded only on accept, so requesters may change
    // their inputs freely once the handshake has happened.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_op_sel <= '0;
        end else if (w_accept) begin
            r_op_a   <= w_grant_a;
            r_op_b   <= w_grant_b;
            r_op_sel <= w_grant_sel;
        end
    end

    // Response registers: capture the ALU outputs at the end of EXEC and
    // hold them unchanged through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_zero  <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_rsp_data  <= alu_out;
            r_rsp_carry <= alu_carry;
            r_rsp_zero  <= alu_zero;
        end
    end

    assign alu_a     = r_op_a;
    assign alu_b     = r_op_b;
    assign alu_sel   = r_op_sel;
    assign rsp_data  = r_rsp_data;
    assign rsp_carry = r_rsp_carry;
    assign rsp_zero  = r_rsp_zero;
    assign busy      = (r_state != ST_IDLE);
    assign owner     = r_owner;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int SEL_W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    initial forever #5 clk = ~clk;

    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
    logic [SEL_W-1:0] req_sel0 = '0, req_sel1 = '0;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready = '0;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_carry, rsp_zero;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic [SEL_W-1:0] alu_sel;
    logic             alu_carry, alu_zero;
    logic             busy, owner;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH+1:0] exp_q[$];

    alu_arbiter #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .req_sel0(req_sel0), .req_sel1(req_sel1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .busy(busy), .owner(owner), .dbg_state(dbg_state)
    );

    // ALU behaviour: returns {carry, zero, result}.
    function automatic logic [WIDTH+1:0] ref_alu(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [SEL_W-1:0] sel);
        logic [WIDTH:0]   t;
        logic [WIDTH-1:0] r;
        logic             c;
        t = '0;
        c = 1'b0;
        case (sel)
            4'd1: begin t = {1'b0, a} + {1'b0, b}; r = t[WIDTH-1:0]; c = t[WIDTH]; end
            4'd2: begin t = {1'b0, a} - {1'b0, b}; r = t[WIDTH-1:0]; c = t[WIDTH]; end
            4'd3: r = a & b;
            4'd4: r = a | b;
            default: r = a ^ b;
        endcase
        return {c, (r == '0), r};
    endfunction

    // ALU stub wired to the arbiter's ALU port.
    always_comb {alu_carry, alu_zero, alu_out} = ref_alu(alu_a, alu_b, alu_sel);

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int k, input logic v, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic [SEL_W-1:0] sel);
        req_valid[k] = v;
        if (k == 0) begin
            req_a0 = a; req_b0 = b; req_sel0 = sel;
        end else begin
            req_a1 = a; req_b1 = b; req_sel1 = sel;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one op and return once the response is being presented
    // (caller sits 1 time unit after the EXEC edge).
    task automatic run_op(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [SEL_W-1:0] sel, output bit ok);
        ok = 1'b0;
        tick();
        drive_req(k, 1'b1, a, b, sel);
        #1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready[k]) begin
                ok = 1'b1;
                break;
            end
            tick();
            #1;
        end
        tick();
        req_valid[k] = 1'b0;
        tick();
    endtask

    task automatic release_rsp(input int k);
        rsp_ready[k] = 1'b1;
        tick();
        rsp_ready = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        #2;
        n_checks++; if (req_ready !== 2'b00) begin n_errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        n_checks++; if (rsp_valid !== 2'b00) begin n_errors++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
        n_checks++; if ({rsp_data, rsp_carry, rsp_zero} !== '0) begin n_errors++; $display("FAIL reset_rsp_regs got=%h/%b/%b exp=0/0/0", rsp_data, rsp_carry, rsp_zero); end
        n_checks++; if ({alu_a, alu_b, alu_sel} !== '0) begin n_errors++; $display("FAIL reset_alu_ops got=%h/%h/%h exp=0/0/0", alu_a, alu_b, alu_sel); end
        n_checks++; if ({busy, owner} !== 2'b00) begin n_errors++; $display("FAIL reset_busy_owner got=%b%b exp=00", busy, owner); end
        apply_reset();
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        tick();
        drive_req(0, 1'b1, 32'd2, 32'd2, 4'd1);
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL single_ready got=%b exp=01", req_ready); end
        tick();
        req_valid[0] = 1'b0;
        #1;
        n_checks++; if (alu_a !== 32'd2 || alu_b !== 32'd2 || alu_sel !== 4'd1) begin n_errors++; $display("FAIL single_alu_ops got=%h/%h/%h exp=2/2/1", alu_a, alu_b, alu_sel); end
        n_checks++; if ({busy, req_ready, rsp_valid} !== 5'b10000) begin n_errors++; $display("FAIL single_exec got=busy%b rdy%b rv%b exp=busy1 rdy00 rv00", busy, req_ready, rsp_valid); end
        tick();
        #1;
        n_checks++; if (rsp_valid !== 2'b01) begin n_errors++; $display("FAIL single_rsp_valid got=%b exp=01", rsp_valid); end
        n_checks++; if (rsp_data !== 32'd4 || rsp_zero !== 1'b0 || rsp_carry !== 1'b0) begin n_errors++; $display("FAIL single_rsp_data got=%h/%b/%b exp=4/0/0", rsp_data, rsp_carry, rsp_zero); end
        release_rsp(0);
        #1;
        n_checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin n_errors++; $display("FAIL single_release got=rv%b busy%b exp=rv00 busy0", rsp_valid, busy); end
    endtask

    task automatic test_tie();
        apply_reset();
        tick();
        drive_req(0, 1'b1, 32'd5, 32'd3, 4'd1);
        drive_req(1, 1'b1, 32'd7, 32'd7, 4'd1);
        rsp_ready = 2'b11;
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL tie1_ready got=%b exp=01", req_ready); end
        tick();
        req_valid[0] = 1'b0;
        #1;
        n_checks++; if (owner !== 1'b0 || req_ready !== 2'b00) begin n_errors++; $display("FAIL tie1_owner got=own%b rdy%b exp=own0 rdy00", owner, req_ready); end
        tick();
        #1;
        n_checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd8) begin n_errors++; $display("FAIL tie1_rsp got=rv%b d%h exp=rv01 d8", rsp_valid, rsp_data); end
        tick();
        #1;
        n_checks++; if (busy !== 1'b0 || req_ready !== 2'b10) begin n_errors++; $display("FAIL tie2_ready got=busy%b rdy%b exp=busy0 rdy10", busy, req_ready); end
        tick();
        req_valid[1] = 1'b0;
        #1;
        n_checks++; if (owner !== 1'b1) begin n_errors++; $display("FAIL tie2_owner got=%b exp=1", owner); end
        tick();
        drive_req(0, 1'b1, 32'd1, 32'd1, 4'd1);
        drive_req(1, 1'b1, 32'd3, 32'd3, 4'd1);
        #1;
        n_checks++; if (rsp_valid !== 2'b10 || rsp_data !== 32'd14) begin n_errors++; $display("FAIL tie2_rsp got=rv%b d%h exp=rv10 de", rsp_valid, rsp_data); end
        tick();
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL tie3_ready got=%b exp=01", req_ready); end
        tick();
        req_valid = '0;
        #1;
        n_checks++; if (owner !== 1'b0) begin n_errors++; $display("FAIL tie3_owner got=%b exp=0", owner); end
        tick();
        #1;
        n_checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd2) begin n_errors++; $display("FAIL tie3_rsp got=rv%b d%h exp=rv01 d2", rsp_valid, rsp_data); end
        tick();
        rsp_ready = '0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL tie_idle got=%b exp=0", busy); end
    endtask

    task automatic test_backpressure();
        tick();
        drive_req(0, 1'b1, 32'd10, 32'd20, 4'd1);
        rsp_ready = '0;
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL bp_ready0 got=%b exp=01", req_ready); end
        tick();
        req_valid[0] = 1'b0;
        drive_req(1, 1'b1, 32'd9, 32'd6, 4'd3);
        #1;
        n_checks++; if (req_ready !== 2'b00) begin n_errors++; $display("FAIL bp_exec_ready got=%b exp=00", req_ready); end
        tick();
        rsp_ready = 2'b10;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd30 || req_ready !== 2'b00) begin n_errors++; $display("FAIL bp_hold%0d got=rv%b d%h rdy%b exp=rv01 d1e rdy00", i, rsp_valid, rsp_data, req_ready); end
            tick();
            #1;
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = '0;
        #1;
        n_checks++; if (busy !== 1'b0 || req_ready !== 2'b10) begin n_errors++; $display("FAIL bp_r1_ready got=busy%b rdy%b exp=busy0 rdy10", busy, req_ready); end
        tick();
        req_valid[1] = 1'b0;
        #1;
        n_checks++; if (owner !== 1'b1 || busy !== 1'b1 || alu_a !== 32'd9) begin n_errors++; $display("FAIL bp_r1_accept got=own%b busy%b a%h exp=own1 busy1 a9", owner, busy, alu_a); end
        tick();
        #1;
        n_checks++; if (rsp_valid !== 2'b10 || rsp_data !== 32'd0 || rsp_zero !== 1'b1 || rsp_carry !== 1'b0) begin n_errors++; $display("FAIL bp_r1_rsp got=rv%b d%h c%b z%b exp=rv10 d0 c0 z1", rsp_valid, rsp_data, rsp_carry, rsp_zero); end
        release_rsp(1);
    endtask

    task automatic test_flags();
        bit ok;
        run_op(0, 32'hFFFF_FFFF, 32'd1, 4'd1, ok);
        #1;
        n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL flags_accept got=%b exp=1", ok); end
        n_checks++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd0 || rsp_carry !== 1'b1 || rsp_zero !== 1'b1) begin n_errors++; $display("FAIL flags_rsp got=rv%b d%h c%b z%b exp=rv01 d0 c1 z1", rsp_valid, rsp_data, rsp_carry, rsp_zero); end
        release_rsp(0);
    endtask

    task automatic test_isolation();
        tick();
        drive_req(1, 1'b1, 32'd100, 32'd23, 4'd2);
        #1;
        n_checks++; if (req_ready !== 2'b10) begin n_errors++; $display("FAIL iso_ready got=%b exp=10", req_ready); end
        tick();
        req_valid[1] = 1'b0;
        req_a1 = 32'hDEAD;
        req_b1 = 32'd0;
        #1;
        n_checks++; if (alu_a !== 32'd100 || alu_b !== 32'd23) begin n_errors++; $display("FAIL iso_exec_ops got=%h/%h exp=64/17", alu_a, alu_b); end
        tick();
        #1;
        n_checks++; if (alu_a !== 32'd100) begin n_errors++; $display("FAIL iso_resp_a got=%h exp=64", alu_a); end
        n_checks++; if (rsp_valid !== 2'b10 || rsp_data !== 32'd77) begin n_errors++; $display("FAIL iso_rsp got=rv%b d%h exp=rv10 d4d", rsp_valid, rsp_data); end
        release_rsp(1);
    endtask

    task automatic test_reset_midop();
        bit ok;
        run_op(0, 32'd7, 32'd8, 4'd1, ok);
        #1;
        n_checks++; if (ok !== 1'b1 || rsp_valid !== 2'b01) begin n_errors++; $display("FAIL midop_pre got=ok%b rv%b exp=ok1 rv01", ok, rsp_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_data !== 32'd0) begin n_errors++; $display("FAIL midop_reset got=rv%b busy%b d%h exp=rv00 busy0 d0", rsp_valid, busy, rsp_data); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive_req(0, 1'b1, 32'd1, 32'd2, 4'd1);
        drive_req(1, 1'b1, 32'd3, 32'd4, 4'd1);
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL midop_tie got=%b exp=01", req_ready); end
        tick();
        req_valid = '0;
        #1;
        n_checks++; if (owner !== 1'b0 || alu_a !== 32'd1) begin n_errors++; $display("FAIL midop_owner got=own%b a%h exp=own0 a1", owner, alu_a); end
        tick();
        #1;
        n_checks++; if (rsp_data !== 32'd3) begin n_errors++; $display("FAIL midop_rsp got=%h exp=3", rsp_data); end
        release_rsp(0);
    endtask

    // Randomized traffic against a transaction model: at most one op
    // outstanding, grant per round-robin rule, response presented from the
    // second edge after accept until the owner takes it.
    task automatic test_random();
        logic [WIDTH-1:0] p_a[2];
        logic [WIDTH-1:0] p_b[2];
        logic [SEL_W-1:0] p_sel[2];
        bit               p_v[2];
        bit               m_busy, s_req_hs, s_rsp_hs;
        int               m_cnt;
        logic             m_owner, m_last, s_grant;
        logic [WIDTH+1:0] s_exp, head;
        logic [1:0]       exp_ready, exp_rv;

        apply_reset();
        exp_q.delete();
        m_busy = 1'b0; m_cnt = 0; m_owner = 1'b0; m_last = 1'b1;
        s_req_hs = 1'b0; s_rsp_hs = 1'b0; s_grant = 1'b0; s_exp = '0;
        for (int k = 0; k < 2; k++) begin
            p_v[k] = 1'b0; p_a[k] = '0; p_b[k] = '0; p_sel[k] = '0;
        end

        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            if (m_busy) begin
                if (s_rsp_hs) begin
                    void'(exp_q.pop_front());
                    m_busy = 1'b0;
                end else begin
                    m_cnt++;
                end
            end
            if (s_req_hs) begin
                exp_q.push_back(s_exp);
                m_busy = 1'b1; m_cnt = 0;
                m_owner = s_grant; m_last = s_grant;
                p_v[s_grant] = 1'b0;
                p_a[s_grant] = $urandom;
            end
            for (int k = 0; k < 2; k++) begin
                if (!p_v[k]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        p_v[k]   = 1'b1;
                        p_a[k]   = $urandom;
                        p_b[k]   = ($urandom_range(0, 3) == 0) ? p_a[k] : $urandom;
                        p_sel[k] = SEL_W'($urandom_range(0, 5));
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    p_v[k] = 1'b0;
                end
            end
            req_valid = {p_v[1], p_v[0]};
            req_a0 = p_a[0]; req_b0 = p_b[0]; req_sel0 = p_sel[0];
            req_a1 = p_a[1]; req_b1 = p_b[1]; req_sel1 = p_sel[1];
            rsp_ready = 2'($urandom_range(0, 3));
            #1;

            exp_ready = 2'b00;
            s_req_hs = 1'b0;
            if (!m_busy && (p_v[0] || p_v[1])) begin
                s_grant = (p_v[0] && p_v[1]) ? ~m_last : p_v[1];
                exp_ready[s_grant] = 1'b1;
                s_req_hs = 1'b1;
                s_exp = ref_alu(p_a[s_grant], p_b[s_grant], p_sel[s_grant]);
            end
            n_checks++; if (req_ready !== exp_ready) begin n_errors++; $display("FAIL rand_req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready); end

            exp_rv = 2'b00;
            s_rsp_hs = 1'b0;
            if (m_busy && m_cnt >= 1) begin
                exp_rv[m_owner] = 1'b1;
                s_rsp_hs = rsp_ready[m_owner];
                head = exp_q[0];
                n_checks++; if ({rsp_carry, rsp_zero, rsp_data} !== head) begin n_errors++; $display("FAIL rand_rsp cyc=%0d got=c%b z%b d%h exp=c%b z%b d%h", cyc, rsp_carry, rsp_zero, rsp_data, head[WIDTH+1], head[WIDTH], head[WIDTH-1:0]); end
            end
            n_checks++; if (rsp_valid !== exp_rv) begin n_errors++; $display("FAIL rand_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv); end
            n_checks++; if (busy !== m_busy) begin n_errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, m_busy); end
            if (m_busy) begin
                n_checks++; if (owner !== m_owner) begin n_errors++; $display("FAIL rand_owner cyc=%0d got=%b exp=%b", cyc, owner, m_owner); end
            end
        end

        req_valid = '0;
        rsp_ready = 2'b11;
        repeat (4) tick();
        rsp_ready = '0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rand_drain got=%b exp=0", busy); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_flags();
        test_isolation();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
